// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/stop/clear FSM with cascaded cs/s/min/h counters; optional lap freeze under STOPWATCH_LAP_EN
module stopwatch_ctrl #(
  parameter int MSEC_MAX = 100,
  parameter int SEC_MAX  = 60,
  parameter int MIN_MAX  = 60,
  parameter int HOUR_MAX = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_lap,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_state,
  output logic       o_tick_en
);
  localparam logic [1:0] S_STOP  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [6:0] MSEC_LAST = 7'(MSEC_MAX - 1);
  localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX - 1);
  localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX - 1);
  localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX - 1);
  logic [1:0] state_q, state_d;
  logic       run_prev_q, clr_prev_q;
  logic [6:0] msec_q, msec_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic       run_ev, clr_ev, count_en;
  logic       msec_wrap, sec_wrap, min_wrap, hour_wrap;
  assign run_ev   = i_btn_run & ~run_prev_q;
  assign clr_ev   = i_btn_clear & ~clr_prev_q;
  assign count_en = i_tick & (state_q == S_RUN);
  // next state: clear beats run in STOP, CLEAR is a single cycle, unused encoding falls back to STOP
  always_comb begin
    state_d = (state_q == S_STOP) ? (clr_ev ? S_CLEAR : (run_ev ? S_RUN : S_STOP)) :
              (state_q == S_RUN)  ? (run_ev ? S_STOP : S_RUN) : S_STOP;
  end
  // cascaded counters: every carry resolves in the same cycle as the tick
  always_comb begin
    msec_wrap = msec_q == MSEC_LAST;
    sec_wrap  = sec_q == SEC_LAST;
    min_wrap  = min_q == MIN_LAST;
    hour_wrap = hour_q == HOUR_LAST;
    msec_d = msec_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (state_q == S_CLEAR) begin
      msec_d = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (count_en) begin
      msec_d = msec_wrap ? '0 : msec_q + 7'd1;
      if (msec_wrap) sec_d = sec_wrap ? '0 : sec_q + 6'd1;
      if (msec_wrap && sec_wrap) min_d = min_wrap ? '0 : min_q + 6'd1;
      if (msec_wrap && sec_wrap && min_wrap) hour_d = hour_wrap ? '0 : hour_q + 5'd1;
    end
  end
  // state, button history and live counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_STOP;
      run_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
      msec_q     <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
    end else begin
      state_q    <= state_d;
      run_prev_q <= i_btn_run;
      clr_prev_q <= i_btn_clear;
      msec_q     <= msec_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
    end
  end
  assign o_state   = state_q;
  assign o_tick_en = state_q == S_RUN;
`ifdef STOPWATCH_LAP_EN
  logic       lap_prev_q, lap_ev;
  logic       freeze_q, freeze_d;
  logic [6:0] snap_msec_q;
  logic [5:0] snap_sec_q, snap_min_q;
  logic [4:0] snap_hour_q;
  assign lap_ev = i_btn_lap & ~lap_prev_q;
  // freeze toggles on lap only in RUN; stopping the run releases it, as does any other state
  always_comb begin
    freeze_d = (state_q == S_RUN) ? (run_ev ? 1'b0 : (lap_ev ? ~freeze_q : freeze_q)) : 1'b0;
  end
  // snapshot the displayed time on the cycle the freeze engages
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_prev_q  <= 1'b0;
      freeze_q    <= 1'b0;
      snap_msec_q <= '0;
      snap_sec_q  <= '0;
      snap_min_q  <= '0;
      snap_hour_q <= '0;
    end else begin
      lap_prev_q <= i_btn_lap;
      freeze_q   <= freeze_d;
      if (freeze_d && !freeze_q) begin
        snap_msec_q <= msec_q;
        snap_sec_q  <= sec_q;
        snap_min_q  <= min_q;
        snap_hour_q <= hour_q;
      end
    end
  end
  assign o_msec = freeze_q ? snap_msec_q : msec_q;
  assign o_sec  = freeze_q ? snap_sec_q : sec_q;
  assign o_min  = freeze_q ? snap_min_q : min_q;
  assign o_hour = freeze_q ? snap_hour_q : hour_q;
`else
  logic unused_lap;
  assign unused_lap = i_btn_lap;
  assign o_msec = msec_q;
  assign o_sec  = sec_q;
  assign o_min  = min_q;
  assign o_hour = hour_q;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench, full-size and reduced-modulus instances against a total-centisecond model
module tb_stopwatch_ctrl;
  localparam int DAY = 8640000;
  logic clk = 0, rst = 0, run = 0, clr = 0, lap = 0, tick = 0;
  logic [1:0] st_a, st_b;
  logic en_a, en_b;
  logic [6:0] ms_a, ms_b;
  logic [5:0] s_a, s_b, m_a, m_b;
  logic [4:0] h_a, h_b;
  always #5 clk = ~clk;
  stopwatch_ctrl dut (
    .clk(clk), .rst(rst), .i_tick(tick), .i_btn_run(run), .i_btn_clear(clr), .i_btn_lap(lap),
    .o_msec(ms_a), .o_sec(s_a), .o_min(m_a), .o_hour(h_a), .o_state(st_a), .o_tick_en(en_a));
  stopwatch_ctrl #(.MSEC_MAX(5), .SEC_MAX(3), .MIN_MAX(2), .HOUR_MAX(2)) dut_w (
    .clk(clk), .rst(rst), .i_tick(tick), .i_btn_run(run), .i_btn_clear(clr), .i_btn_lap(lap),
    .o_msec(ms_b), .o_sec(s_b), .o_min(m_b), .o_hour(h_b), .o_state(st_b), .o_tick_en(en_b));
  typedef struct {int cyc; logic [26:0] a; logic [26:0] b;} exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0, cyc = 0;
  int m_st = 0, m_t = 0, m_snap = 0;
  bit m_frz = 0, m_rp = 0, m_cp = 0, m_lp = 0;
  function automatic logic [26:0] fmt(int st, int t, int ms, int ss, int mn, int hh);
    logic [26:0] r;
    r = {2'(st), st == 1, 7'(t % ms), 6'((t / ms) % ss), 6'((t / (ms * ss)) % mn),
         5'((t / (ms * ss * mn)) % hh)};
    return r;
  endfunction
  task automatic step(input bit r, input bit ru, input bit cl, input bit la, input bit ti);
    bit rev, cev, lev;
    int shown;
    exp_t e;
    @(negedge clk);
    rst = r; run = ru; clr = cl; lap = la; tick = ti;
    if (r) begin
      m_st = 0; m_t = 0; m_frz = 0; m_snap = 0; m_rp = 0; m_cp = 0; m_lp = 0;
    end else begin
      rev = ru && !m_rp;
      cev = cl && !m_cp;
      lev = la && !m_lp;
`ifdef STOPWATCH_LAP_EN
      if (m_st != 1 || rev) m_frz = 0;
      else if (lev) begin
        if (!m_frz) m_snap = m_t;
        m_frz = !m_frz;
      end
`else
      lev = 0;
`endif
      if (m_st == 2) m_t = 0;
      else if (m_st == 1 && ti) m_t = (m_t + 1) % DAY;
      m_st = (m_st == 0) ? (cev ? 2 : (rev ? 1 : 0)) : (m_st == 1) ? (rev ? 0 : 1) : 0;
      m_rp = ru; m_cp = cl; m_lp = la;
    end
    shown = m_frz ? m_snap : m_t;
    e.cyc = cyc;
    e.a = fmt(m_st, shown, 100, 60, 60, 24);
    e.b = fmt(m_st, shown, 5, 3, 2, 2);
    sb.push_back(e);
    cyc++;
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        logic [26:0] ga, gb;
        e = sb.pop_front();
        ga = {st_a, en_a, ms_a, s_a, m_a, h_a};
        gb = {st_b, en_b, ms_b, s_b, m_b, h_b};
        checks++;
        if (ga === e.a) passed++;
        else $display("FAIL cyc %0d full: got st/en/hh:mm:ss.cc=%h exp=%h", e.cyc, ga, e.a);
        checks++;
        if (gb === e.b) passed++;
        else $display("FAIL cyc %0d small: got st/en/hh:mm:ss.cc=%h exp=%h", e.cyc, gb, e.b);
      end
    end
  end
  task automatic restart();
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask
  initial begin
    bit r_run, r_clr, r_lap;
    restart();
    repeat (150) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
    end
    restart();
    repeat (10) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1);
    restart();
    repeat (500) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    restart();
    repeat (59) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    restart();
    repeat (50) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    repeat (30) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    r_run = 0; r_clr = 0; r_lap = 0;
    repeat (4000) begin
      if ($urandom_range(0, 9) == 0) r_run = !r_run;
      if ($urandom_range(0, 29) == 0) r_clr = !r_clr;
      if ($urandom_range(0, 7) == 0) r_lap = !r_lap;
      step($urandom_range(0, 299) == 0, r_run, r_clr, r_lap, $urandom_range(0, 1) == 1);
    end
    repeat (2) step(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending entries, exp 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
